// File: rtl/master_port.sv
// master_port: serial-bus master port; requests the bus, shifts address and write data out LSB-first,
// and reassembles LSB-first serial read data. Define MASTER_PORT_TIMEOUT_EN for the read-wait timeout.
module master_port #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  dstart_i,
    input  logic                  dmode_i,
    input  logic [ADDR_WIDTH-1:0] daddr_i,
    input  logic [DATA_WIDTH-1:0] dwdata_i,
    output logic [DATA_WIDTH-1:0] drdata_o,
    output logic                  dready_o,
    output logic                  ddone_o,
    output logic                  derr_o,
    output logic                  mbreq_o,
    input  logic                  mbgrant_i,
    output logic                  mwdata_o,
    output logic                  mmode_o,
    output logic                  mvalid_o,
    input  logic                  srdata_i,
    input  logic                  svalid_i
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(DATA_WIDTH - 2);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE} state_e;

    state_e                state_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] drdata_q;
    logic                  dready_q;
    logic                  ddone_q;
    logic                  derr_q;
    logic                  mbreq_q;
    logic                  mwdata_q;
    logic                  mmode_q;
    logic                  mvalid_q;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_q;
`else
    // The timeout limit is only consulted when the wait counter is compiled in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Bits arrive LSB-first, so shifting in from the top aligns the word after DATA_WIDTH captures.
    always_comb begin
        rd_d = {srdata_i, rd_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            drdata_q <= '0;
            dready_q <= 1'b1;
            ddone_q  <= 1'b0;
            derr_q   <= 1'b0;
            mbreq_q  <= 1'b0;
            mwdata_q <= 1'b0;
            mmode_q  <= 1'b0;
            mvalid_q <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            ddone_q <= 1'b0;
            derr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dstart_i) begin
                        mode_q   <= dmode_i;
                        addr_q   <= daddr_i;
                        wdata_q  <= dwdata_i;
                        dready_q <= 1'b0;
                        mbreq_q  <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (mbgrant_i) begin
                        state_q  <= ADDR;
                        mvalid_q <= 1'b1;
                        mmode_q  <= mode_q;
                        mwdata_q <= addr_q[0];
                        addr_q   <= addr_q >> 1;
                        cnt_q    <= '0;
                    end
                end
                ADDR: begin
                    if (cnt_q == A_LAST) begin
                        cnt_q <= '0;
                        if (mode_q) begin
                            state_q  <= WDATA;
                            mwdata_q <= wdata_q[0];
                            wdata_q  <= wdata_q >> 1;
                        end else begin
                            state_q  <= RWAIT;
                            mvalid_q <= 1'b0;
                            mwdata_q <= 1'b0;
                            mmode_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        mwdata_q <= addr_q[0];
                        addr_q   <= addr_q >> 1;
                    end
                end
                WDATA: begin
                    if (cnt_q == D_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= DONE;
                        mvalid_q <= 1'b0;
                        mwdata_q <= 1'b0;
                        mmode_q  <= 1'b0;
                        mbreq_q  <= 1'b0;
                        ddone_q  <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        mwdata_q <= wdata_q[0];
                        wdata_q  <= wdata_q >> 1;
                    end
                end
                RWAIT: begin
                    if (svalid_i) begin
                        rd_q  <= rd_d;
                        cnt_q <= '0;
`ifdef MASTER_PORT_TIMEOUT_EN
                        wait_q <= '0;
`endif
                        if (DATA_WIDTH == 1) begin
                            state_q  <= DONE;
                            ddone_q  <= 1'b1;
                            mbreq_q  <= 1'b0;
                            drdata_q <= rd_d;
                        end else begin
                            state_q <= RDATA;
                        end
                    end
`ifdef MASTER_PORT_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        state_q <= DONE;
                        ddone_q <= 1'b1;
                        derr_q  <= 1'b1;
                        mbreq_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
`endif
                end
                RDATA: begin
                    // cnt_q counts captures after the first bit taken in RWAIT.
                    if (svalid_i) begin
                        rd_q <= rd_d;
`ifdef MASTER_PORT_TIMEOUT_EN
                        wait_q <= '0;
`endif
                        if (cnt_q == R_LAST) begin
                            cnt_q    <= '0;
                            state_q  <= DONE;
                            ddone_q  <= 1'b1;
                            mbreq_q  <= 1'b0;
                            drdata_q <= rd_d;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`ifdef MASTER_PORT_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= DONE;
                        ddone_q <= 1'b1;
                        derr_q  <= 1'b1;
                        mbreq_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
`endif
                end
                DONE: begin
                    state_q  <= IDLE;
                    dready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drdata_o = drdata_q;
    assign dready_o = dready_q;
    assign ddone_o  = ddone_q;
    assign derr_o   = derr_q;
    assign mbreq_o  = mbreq_q;
    assign mwdata_o = mwdata_q;
    assign mmode_o  = mmode_q;
    assign mvalid_o = mvalid_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write/read serialization, grant delay, svalid gaps, reset abort,
// and (with MASTER_PORT_TIMEOUT_EN) the read-wait timeout.
module tb_master_port;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dstart = 1'b0;
    logic        dmode = 1'b0;
    logic [11:0] daddr = '0;
    logic [7:0]  dwdata = '0;
    logic [7:0]  drdata;
    logic        dready, ddone, derr, mbreq, mwdata, mmode, mvalid;
    logic        mbgrant = 1'b0;
    logic        srdata = 1'b0;
    logic        svalid = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .dstart_i(dstart), .dmode_i(dmode),
        .daddr_i(daddr), .dwdata_i(dwdata), .drdata_o(drdata), .dready_o(dready),
        .ddone_o(ddone), .derr_o(derr), .mbreq_o(mbreq), .mbgrant_i(mbgrant),
        .mwdata_o(mwdata), .mmode_o(mmode), .mvalid_o(mvalid),
        .srdata_i(srdata), .svalid_i(svalid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        tick(); tick();
        vectors++;
        if ({dready, ddone, derr, mbreq, mwdata, mmode, mvalid} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {dready, ddone, derr, mbreq, mwdata, mmode, mvalid});
        end
        vectors++;
        if (drdata !== 8'h00) begin
            miscompares++; $display("FAIL reset_drdata: got %h expected 00", drdata);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_write;
        logic [19:0] bits;
        bits = {8'h3E, 12'hA5C};
        mbgrant = 1'b1; dmode = 1'b1; daddr = 12'hA5C; dwdata = 8'h3E; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        vectors++;
        if ({dready, mbreq, mvalid} !== 3'b010) begin
            miscompares++; $display("FAIL write_req: got %b expected 010", {dready, mbreq, mvalid});
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if ({mvalid, mmode, mwdata} !== {2'b11, bits[i]}) begin
                miscompares++;
                $display("FAIL write_bit%0d: got %b expected %b", i, {mvalid, mmode, mwdata}, {2'b11, bits[i]});
            end
        end
        tick();
        vectors++;
        if ({ddone, derr, mbreq, mvalid, dready} !== 5'b10000 || drdata !== 8'h00) begin
            miscompares++;
            $display("FAIL write_done: got %b/%h expected 10000/00", {ddone, derr, mbreq, mvalid, dready}, drdata);
        end
        tick();
        vectors++;
        if ({ddone, dready} !== 2'b01) begin
            miscompares++; $display("FAIL write_idle: got %b expected 01", {ddone, dready});
        end
    endtask

    task automatic test_read;
        logic [11:0] abits;
        logic [7:0]  rbits;
        abits = 12'h123;
        rbits = 8'h5A;
        mbgrant = 1'b1; dmode = 1'b0; daddr = 12'h123; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if ({mvalid, mmode, mwdata} !== {2'b10, abits[i]}) begin
                miscompares++;
                $display("FAIL read_bit%0d: got %b expected %b", i, {mvalid, mmode, mwdata}, {2'b10, abits[i]});
            end
        end
        tick();
        vectors++;
        if ({mvalid, mwdata, mmode, mbreq, ddone} !== 5'b00010) begin
            miscompares++;
            $display("FAIL read_rwait: got %b expected 00010", {mvalid, mwdata, mmode, mbreq, ddone});
        end
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            svalid = 1'b1; srdata = rbits[i];
            tick();
        end
        svalid = 1'b0; srdata = 1'b0;
        vectors++;
        if ({ddone, derr, mbreq} !== 3'b100 || drdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL read_done: got %b/%h expected 100/5a", {ddone, derr, mbreq}, drdata);
        end
        tick();
        vectors++;
        if ({ddone, dready} !== 2'b01 || drdata !== 8'h5A) begin
            miscompares++; $display("FAIL read_idle: got %b/%h expected 01/5a", {ddone, dready}, drdata);
        end
    endtask

    task automatic test_grant_delay;
        logic [19:0] bits;
        bits = {8'h81, 12'h3C5};
        mbgrant = 1'b0; dmode = 1'b1; daddr = 12'h3C5; dwdata = 8'h81; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            vectors++;
            if ({mbreq, mvalid} !== 2'b10) begin
                miscompares++; $display("FAIL grant_wait%0d: got %b expected 10", k, {mbreq, mvalid});
            end
        end
        mbgrant = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 2) mbgrant = 1'b0;
            vectors++;
            if ({mvalid, mwdata} !== {1'b1, bits[i]}) begin
                miscompares++;
                $display("FAIL grant_bit%0d: got %b expected %b", i, {mvalid, mwdata}, {1'b1, bits[i]});
            end
        end
        tick();
        vectors++;
        if ({ddone, mbreq, mvalid} !== 3'b100) begin
            miscompares++; $display("FAIL grant_done: got %b expected 100", {ddone, mbreq, mvalid});
        end
        tick();
    endtask

    task automatic test_gaps;
        logic [11:0] vmask;
        logic [7:0]  rbits;
        int b;
        int extra;
        vmask = 12'b1110_1110_0110;
        rbits = 8'hC3;
        b = 0;
        extra = 0;
        mbgrant = 1'b1; dmode = 1'b0; daddr = 12'h0F0; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        for (int c = 1; c <= 11; c++) begin
            svalid = vmask[c];
            srdata = vmask[c] ? rbits[b] : 1'b0;
            if (vmask[c]) b++;
            dstart = (c == 4); dmode = 1'b1; daddr = 12'h555;
            if (ddone) extra++;
            tick();
        end
        svalid = 1'b0; srdata = 1'b0; dstart = 1'b0;
        vectors++;
        if (ddone !== 1'b1 || drdata !== 8'hC3) begin
            miscompares++; $display("FAIL gaps_done: got %b/%h expected 1/c3", ddone, drdata);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ddone || mbreq) extra++;
        end
        vectors++;
        if (extra !== 0 || dready !== 1'b1) begin
            miscompares++; $display("FAIL gaps_single: got extra=%0d ready=%b expected 0/1", extra, dready);
        end
    endtask

`ifdef MASTER_PORT_TIMEOUT_EN
    task automatic test_timeout;
        int extra;
        extra = 0;
        mbgrant = 1'b1; dmode = 1'b0; daddr = 12'h2AA; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        for (int k = 1; k < 16; k++) begin
            tick();
            if (ddone) extra++;
        end
        tick();
        vectors++;
        if ({ddone, derr, mbreq} !== 3'b110 || drdata !== 8'hC3 || extra !== 0) begin
            miscompares++;
            $display("FAIL timeout_done: got %b/%h early=%0d expected 110/c3/0", {ddone, derr, mbreq}, drdata, extra);
        end
        tick();
        vectors++;
        if ({ddone, derr, dready} !== 3'b001) begin
            miscompares++; $display("FAIL timeout_idle: got %b expected 001", {ddone, derr, dready});
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [19:0] bits;
        int extra;
        extra = 0;
        mbgrant = 1'b1; dmode = 1'b1; daddr = 12'hA5C; dwdata = 8'h3E; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if ({mvalid, mwdata} !== 2'b10) begin
            miscompares++; $display("FAIL abort_bit5: got %b expected 10", {mvalid, mwdata});
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        vectors++;
        if ({dready, ddone, derr, mbreq, mwdata, mmode, mvalid} !== 7'b1000000 || drdata !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_reset: got %b/%h expected 1000000/00",
                     {dready, ddone, derr, mbreq, mwdata, mmode, mvalid}, drdata);
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ddone || mvalid || mbreq) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++; $display("FAIL abort_quiet: got %0d active cycles expected 0", extra);
        end
        bits = {8'hFF, 12'h001};
        daddr = 12'h001; dwdata = 8'hFF; dstart = 1'b1;
        tick();
        dstart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if ({mvalid, mmode, mwdata} !== {2'b11, bits[i]}) begin
                miscompares++;
                $display("FAIL after_bit%0d: got %b expected %b", i, {mvalid, mmode, mwdata}, {2'b11, bits[i]});
            end
        end
        tick();
        vectors++;
        if ({ddone, mbreq, mvalid} !== 3'b100) begin
            miscompares++; $display("FAIL after_done: got %b expected 100", {ddone, mbreq, mvalid});
        end
        tick();
        vectors++;
        if ({ddone, dready} !== 2'b01) begin
            miscompares++; $display("FAIL after_idle: got %b expected 01", {ddone, dready});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_grant_delay();
        test_gaps();
`ifdef MASTER_PORT_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
